sensor_portao: RTL and testbench

- Gate-sensor front end for the parking-lot counter.
- Watches two infrared beams across the lane: A (street side) and B (lot side). It infers the direction each car passed and generates the counter's command pair: somar pulse alone = entry (increment); somar pulse with decrem = exit (decrement).
- Also filters noise, rejects aborted or ambiguous passages and flags entries refused while the lot is full.

---
 rtl/sensor_portao_pkg.sv | 34 +++
 rtl/sensor_portao_if.sv | 15 +
 rtl/sensor_portao_sinc_debounce.sv | 37 +++
 rtl/sensor_portao.sv | 112 +++++++++++
 tb/tb_sensor_portao.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sensor_portao_pkg.sv
// Shared types for the parking-gate sensor front end: FSM states, beam codes
// and the registered output payload.
package sensor_portao_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ENT1   = 3'd1,
    ENT2   = 3'd2,
    ENT3   = 3'd3,
    SAI1   = 3'd4,
    SAI2   = 3'd5,
    SAI3   = 3'd6,
    ESPERA = 3'd7
  } estado_t;

  // Debounced beam pair as {a,b}
  localparam logic [1:0] LIVRE = 2'b00;
  localparam logic [1:0] SO_A  = 2'b10;
  localparam logic [1:0] SO_B  = 2'b01;
  localparam logic [1:0] AMBOS = 2'b11;

  typedef struct packed {
    logic somar;
    logic decrem;
    logic excesso;
    logic erro;
  } saida_t;

  // True while a car is mid-passage (the only states that can time out)
  function automatic logic em_passagem(input estado_t e);
    return (e != OCIOSO) && (e != ESPERA);
  endfunction

endpackage

// File: rtl/sensor_portao_if.sv
// Gate sensor bundle: raw beams and lot-full flag in, counter command strobes out.
interface sensor_portao_if;
  logic sens_a;
  logic sens_b;
  logic lotado;
  logic somar;
  logic decrem;
  logic excesso;
  logic erro;

  modport master (output sens_a, sens_b, lotado,
                  input  somar, decrem, excesso, erro);
  modport slave  (input  sens_a, sens_b, lotado,
                  output somar, decrem, excesso, erro);
endinterface

// File: rtl/sensor_portao_sinc_debounce.sv
// Two-flop synchronizer followed by a stability filter for one raw beam input.
module sinc_debounce
  import sensor_portao_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bruto,
  output logic limpo
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sinc;
  logic [CW-1:0] cnt;

  // Output follows the synced value only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc  <= '0;
      cnt   <= '0;
      limpo <= 1'b0;
    end else begin
      sinc <= {sinc[0], bruto};
      if (sinc[1] == limpo) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        limpo <= sinc[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_portao.sv
// Infers car direction from two debounced beams and issues one count command
// per valid passage; flags refused entries and aborted/ambiguous passages.
module sensor_portao
  import sensor_portao_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic            clk,
  input  logic            reset,
  sensor_portao_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          deb_a;
  logic          deb_b;
  logic [1:0]    ab;
  estado_t       estado;
  estado_t       estado_prox;
  logic [TW-1:0] tmo_cnt;
  logic          tmo;
  saida_t        saida_q;
  saida_t        saida_c;

  sinc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .bruto (bus.sens_a),
    .limpo (deb_a)
  );

  sinc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .bruto (bus.sens_b),
    .limpo (deb_b)
  );

  assign ab  = {deb_a, deb_b};
  assign tmo = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    unique case (estado)
      OCIOSO: if (ab == SO_A) estado_prox = ENT1;
              else if (ab == SO_B) estado_prox = SAI1;
              else if (ab == AMBOS) estado_prox = ESPERA;
      ENT1:   if (ab == AMBOS) estado_prox = ENT2;
              else if (ab == LIVRE) estado_prox = OCIOSO;
              else if (ab == SO_B) estado_prox = ESPERA;
      ENT2:   if (ab == SO_B) estado_prox = ENT3;
              else if (ab == SO_A) estado_prox = ENT1;
              else if (ab == LIVRE) estado_prox = ESPERA;
      ENT3:   if (ab == LIVRE) estado_prox = OCIOSO;
              else if (ab == AMBOS) estado_prox = ENT2;
              else if (ab == SO_A) estado_prox = ESPERA;
      SAI1:   if (ab == AMBOS) estado_prox = SAI2;
              else if (ab == LIVRE) estado_prox = OCIOSO;
              else if (ab == SO_A) estado_prox = ESPERA;
      SAI2:   if (ab == SO_A) estado_prox = SAI3;
              else if (ab == SO_B) estado_prox = SAI1;
              else if (ab == LIVRE) estado_prox = ESPERA;
      SAI3:   if (ab == LIVRE) estado_prox = OCIOSO;
              else if (ab == AMBOS) estado_prox = SAI2;
              else if (ab == SO_B) estado_prox = ESPERA;
      ESPERA: if (ab == LIVRE) estado_prox = OCIOSO;
    endcase
    // A sensor move wins over a timeout landing on the same cycle
    if (em_passagem(estado) && (estado_prox == estado) && tmo)
      estado_prox = ESPERA;
  end

  // Every entry into ESPERA is an error; the strobe-spacing guard never trips
  // for real traffic because debounced inputs cannot move twice in a row.
  always_comb begin
    saida_c = '0;
    if (!(|saida_q)) begin
      saida_c.erro = (estado_prox == ESPERA) && (estado != ESPERA);
      if ((estado == ENT3) && (ab == LIVRE)) begin
        saida_c.somar   = !bus.lotado;
        saida_c.excesso = bus.lotado;
      end
      if ((estado == SAI3) && (ab == LIVRE)) begin
        saida_c.somar  = 1'b1;
        saida_c.decrem = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saida_q <= '0;
      tmo_cnt <= '0;
    end else begin
      saida_q <= saida_c;
      if ((estado_prox != estado) || !em_passagem(estado)) tmo_cnt <= '0;
      else                                                  tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign bus.somar   = saida_q.somar;
  assign bus.decrem  = saida_q.decrem;
  assign bus.excesso = saida_q.excesso;
  assign bus.erro    = saida_q.erro;

endmodule

// File: tb/tb_sensor_portao.sv
// Scenario bench for sensor_portao: expected strobes are queued as each
// sensor sequence is driven and matched against every strobe the DUT emits.
module tb_sensor_portao;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 50;

  localparam logic [3:0] EV_INC = 4'b1000;  // {somar,decrem,excesso,erro}
  localparam logic [3:0] EV_DEC = 4'b1100;
  localparam logic [3:0] EV_EXC = 4'b0010;
  localparam logic [3:0] EV_ERR = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sensor_portao_if bus();

  sensor_portao #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         ev_cyc  = 0;
  int         t0;
  logic [3:0] exp_q[$];
  logic [3:0] obs;
  logic       prev_ev = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    obs = {bus.somar, bus.decrem, bus.excesso, bus.erro};
    if (obs != 4'b0000) begin
      ev_cyc = cyc;
      if (prev_ev) chk("consecutive", 1, 0);
      if (exp_q.size() == 0) chk("unexpected", int'(obs), 0);
      else                   chk("event", int'(obs), int'(exp_q.pop_front()));
    end
    prev_ev = (obs != 4'b0000);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    bus.sens_a = a;
    bus.sens_b = b;
    wait_cyc(n);
  endtask

  task automatic drain(input string tag);
    wait_cyc(20);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic entrada();
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
  endtask

  task automatic saida();
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
  endtask

  initial begin
    reset      = 1'b0;
    bus.sens_a = 1'b0;
    bus.sens_b = 1'b0;
    bus.lotado = 1'b0;
    wait_cyc(3);
    chk("rst_outputs", int'({bus.somar, bus.decrem, bus.excesso, bus.erro}), 0);
    reset = 1'b1;
    wait_cyc(5);

    // Entry, lot not full: one increment, 7 cycles after B clears
    exp_q.push_back(EV_INC);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    t0 = cyc;
    drive(1'b0, 1'b0, 10);
    chk("lat_entry", ev_cyc - t0, 7);
    drain("t1_entry");

    // Exit with lot free and full: decrement both times, no excesso
    exp_q.push_back(EV_DEC);
    saida();
    drain("t2_exit");
    bus.lotado = 1'b1;
    exp_q.push_back(EV_DEC);
    saida();
    drain("t2_exit_full");

    // Entry with lot full: excesso only
    exp_q.push_back(EV_EXC);
    entrada();
    drain("t3_full");
    bus.lotado = 1'b0;

    // Three-cycle glitches on A never reach the FSM
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 3);
    end
    drain("t4_glitch");

    // Reversal A -> AB -> A -> none: silent
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    drain("t4_reversal");

    // Illegal hop A -> B from ENT1
    exp_q.push_back(EV_ERR);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drain("t4_illegal");

    // Timeout: 7 cycles to reach ENT1, then 50 cycles there
    exp_q.push_back(EV_ERR);
    t0 = cyc;
    drive(1'b1, 1'b0, 60);
    chk("lat_timeout", ev_cyc - t0, 57);
    drive(1'b0, 1'b0, 15);
    drain("t5_timeout");

    // FSM back in OCIOSO: a normal exit still counts
    exp_q.push_back(EV_DEC);
    saida();
    drain("t5_recover");

    // Simultaneous start is ambiguous
    exp_q.push_back(EV_ERR);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drain("t5_both");

    // Reset during ENT2 discards the passage
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    reset = 1'b0;
    #1;
    chk("rst_mid", int'({bus.somar, bus.decrem, bus.excesso, bus.erro}), 0);
    bus.sens_a = 1'b0;
    bus.sens_b = 1'b0;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(10);
    drain("t6_discard");
    exp_q.push_back(EV_INC);
    entrada();
    drain("t6_fresh");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
